// File: rtl/mem_arbiter_pkg.sv
// Shared types for the i-cache/d-cache main-memory arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see arb_grant_select).
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 28;   // block address, byte address bits [31:4]
  localparam int BLOCK_W_DEF = 128;  // one block = 4 words

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/arb_grant_select.sv
// Combinational choice of which cache is served next.
// ARB_ROUND_ROBIN_EN undefined: d-cache always wins a tie.
// ARB_ROUND_ROBIN_EN defined: the requester not granted last wins a tie.
// With no request pending the previous grant is simply repeated.
module arb_grant_select
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output grant_e grant
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    grant = last_grant;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end
`else
    if (d_req) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises i-cache refills and d-cache refills/write-backs onto one
// main-memory port, one transaction at a time (IDLE -> REQ -> WAIT -> ACK).
// Optional feature macro: ARB_ROUND_ROBIN_EN (tie-break policy).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  state_e             state_q, state_d;
  grant_e             grant_q, grant_d;
  op_e                op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;

  logic   i_req;
  logic   d_req;
  grant_e sel_grant;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  arb_grant_select u_grant_select (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (grant_q),
    .grant      (sel_grant)
  );

  // Next-state, latch and memory-request logic for the transaction FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    state_d     = state_q;
    grant_d     = grant_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_d = sel_grant;
          state_d = ST_REQ;
          if (sel_grant == GRANT_D) begin
            addr_d  = d_address;
            wdata_d = d_writedata;
            op_d    = d_write ? OP_WRITE : OP_READ;
          end else begin
            addr_d = i_address;
            op_d   = OP_READ;
          end
          // The memory request is registered here, never driven straight from the cache inputs.
          mem_read_d  = (op_d == OP_READ);
          mem_write_d = (op_d == OP_WRITE);
        end
      end
      ST_REQ: begin
        if (mem_busywait) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mem_busywait) begin
          state_d     = ST_ACK;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (op_q == OP_READ) begin
            if (grant_q == GRANT_I) begin
              i_rdata_d = mem_readdata;
            end else begin
              d_rdata_d = mem_readdata;
            end
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_I;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign i_busywait    = i_req & ~((state_q == ST_ACK) & (grant_q == GRANT_I));
  assign d_busywait    = d_req & ~((state_q == ST_ACK) & (grant_q == GRANT_D));
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized
// traffic from both caches, checked by a scoreboard monitor against a
// behavioural memory image and a tie-break model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

  localparam int AW       = 28;
  localparam int BW       = 128;
  localparam int MEM_BUSY = 4;
  localparam int BOUND    = 200;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [BW-1:0] d_writedata;
  logic [BW-1:0] i_readdata, d_readdata;
  logic          i_busywait, d_busywait;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_writedata;
  logic [BW-1:0] mem_readdata;
  logic          mem_busywait;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] blk_default(input logic [5:0] a);
    if (a == 6'h10) return 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000001;
    return {4{24'hC0FFEE, 2'b00, a}};
  endfunction

  // ---------------- memory model: busy one edge after a request, 4 cycles ----------------
  typedef enum {MS_IDLE, MS_BUSY, MS_DONE} ms_e;
  ms_e           ms;
  int            ms_cnt;
  logic [AW-1:0] cap_addr;
  logic          cap_wr;
  logic [BW-1:0] mem_arr [64];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms           <= MS_IDLE;
      ms_cnt       <= 0;
      mem_busywait <= 1'b0;
      mem_readdata <= '0;
      cap_addr     <= '0;
      cap_wr       <= 1'b0;
    end else begin
      case (ms)
        MS_IDLE: if (mem_read || mem_write) begin
          ms           <= MS_BUSY;
          mem_busywait <= 1'b1;
          ms_cnt       <= MEM_BUSY;
          cap_addr     <= mem_address;
          cap_wr       <= mem_write;
          if (mem_write) mem_arr[mem_address[5:0]] <= mem_writedata;
        end
        MS_BUSY: begin
          if (ms_cnt == 1) begin
            mem_busywait <= 1'b0;
            if (!cap_wr) mem_readdata <= mem_arr[cap_addr[5:0]];
            ms <= MS_DONE;
          end else begin
            ms_cnt <= ms_cnt - 1;
          end
        end
        default: if (!(mem_read || mem_write)) ms <= MS_IDLE;
      endcase
    end
  end

  // ---------------- reference state and scoreboard queues ----------------
  typedef struct {bit wr; logic [BW-1:0] data;} d_exp_t;
  typedef struct {logic [AW-1:0] a; logic [BW-1:0] data;} w_exp_t;

  logic [BW-1:0] ref_mem [64];
  logic [BW-1:0] i_q[$];
  d_exp_t        d_q[$];
  w_exp_t        w_exp[$];
  bit            order_q[$];   // 1 = d-cache served, 0 = i-cache served
  logic [BW-1:0] i_last, d_last;
  int            i_acks = 0, d_acks = 0;
  int            i_ack_cyc, d_ack_cyc, i_raise_cyc, d_raise_cyc;
  int            rise_cyc;
  logic [AW-1:0] rise_addr;
  logic          rise_wr;
  logic [BW-1:0] rise_data;

  initial begin
    for (int j = 0; j < 64; j++) begin
      mem_arr[j] = blk_default(6'(j));
      ref_mem[j] = blk_default(6'(j));
    end
  end

  // ---------------- monitor: pops and compares whenever the DUT acknowledges ----------------
  initial begin
    bit ia, da, mreq, mreq_prev;
    d_exp_t e;
    mreq_prev = 1'b0;
    forever begin
      @(negedge clk);
      mreq = mem_read || mem_write;
      if (!reset) begin
        ia = i_read && !i_busywait;
        da = (d_read || d_write) && !d_busywait;
        check("single_ack", 128'(ia && da), 128'(0));
        if (ia) begin
          check("i_ack_pending", 128'(i_q.size() != 0), 128'(1));
          if (i_q.size() != 0) i_last = i_q.pop_front();
          check("i_readdata", i_readdata, i_last);
          i_acks++;
          i_ack_cyc = cyc;
          order_q.push_back(1'b0);
        end else begin
          check("i_readdata_hold", i_readdata, i_last);
        end
        if (da) begin
          check("d_ack_pending", 128'(d_q.size() != 0), 128'(1));
          e.wr = 1'b0;
          if (d_q.size() != 0) begin
            e = d_q.pop_front();
            if (!e.wr) d_last = e.data;
          end
          check(e.wr ? "d_readdata_after_wb" : "d_readdata", d_readdata, d_last);
          d_acks++;
          d_ack_cyc = cyc;
          order_q.push_back(1'b1);
        end else begin
          check("d_readdata_hold", d_readdata, d_last);
        end
        check("mem_op_exclusive", 128'(mem_read && mem_write), 128'(0));
        if (mreq && !mreq_prev) begin
          rise_cyc  = cyc;
          rise_addr = mem_address;
          rise_wr   = mem_write;
          rise_data = mem_writedata;
          if (mem_write) begin
            check("wb_expected", 128'(w_exp.size() != 0), 128'(1));
            if (w_exp.size() != 0) begin
              w_exp_t w;
              w = w_exp.pop_front();
              check("wb_address", 128'(mem_address), 128'(w.a));
              check("wb_data", mem_writedata, w.data);
            end
          end
        end else if (mreq) begin
          check("mem_address_stable", 128'(mem_address), 128'(rise_addr));
          check("mem_write_stable", 128'(mem_write), 128'(rise_wr));
          if (rise_wr) check("mem_writedata_stable", mem_writedata, rise_data);
        end
        if (ms == MS_BUSY) check("mem_req_held_in_wait", 128'(mreq), 128'(1));
      end
      mreq_prev = mreq;
    end
  end

  // ---------------- cache drivers ----------------
  task automatic i_xact(input logic [AW-1:0] a, input bit hold);
    int start;
    bit got;
    i_q.push_back(ref_mem[a[5:0]]);
    @(posedge clk);
    #2;
    i_address   = a;
    i_read      = 1'b1;
    i_raise_cyc = cyc;
    start       = i_acks;
    got         = 1'b0;
    for (int n = 0; n < BOUND && !got; n++) begin
      @(posedge clk);
      got = (i_acks != start);
    end
    check("i_ack_in_time", 128'(got), 128'(1));
    if (!got) i_q.delete();
    if (!hold || !got) begin
      #2;
      i_read = 1'b0;
    end
  endtask

  task automatic d_xact(input logic [AW-1:0] a, input bit wr, input logic [BW-1:0] data, input bit hold);
    int start;
    bit got;
    d_exp_t e;
    e.wr   = wr;
    e.data = '0;
    if (wr) begin
      ref_mem[a[5:0]] = data;
      w_exp.push_back('{a: a, data: data});
    end else begin
      e.data = ref_mem[a[5:0]];
    end
    d_q.push_back(e);
    @(posedge clk);
    #2;
    d_address   = a;
    d_writedata = data;
    d_read      = !wr;
    d_write     = wr;
    d_raise_cyc = cyc;
    start       = d_acks;
    got         = 1'b0;
    for (int n = 0; n < BOUND && !got; n++) begin
      @(posedge clk);
      got = (d_acks != start);
    end
    check("d_ack_in_time", 128'(got), 128'(1));
    if (!got) d_q.delete();
    if (!hold || !got) begin
      #2;
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    i_last = '0;
    d_last = '0;
    i_q.delete();
    d_q.delete();
    w_exp.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Both caches hold their requests for ni / nd transactions from the same edge;
  // the expected service order comes from the tie-break rule, starting after reset (last = I).
  task automatic tie_test(input int ni, input int nd);
    bit exp_seq[$];
    int ri, rd;
    bit last, g;
    ri = ni;
    rd = nd;
    last = 1'b0;
    while (ri > 0 || rd > 0) begin
      if (ri > 0 && rd > 0) g = RR ? !last : 1'b1;
      else                  g = (rd > 0);
      exp_seq.push_back(g);
      last = g;
      if (g) rd--; else ri--;
    end
    order_q.delete();
    fork
      begin
        for (int k = 0; k < ni; k++) i_xact(AW'(28'h0000005), k < ni - 1);
      end
      begin
        for (int k = 0; k < nd; k++) d_xact(AW'(28'h0000025), 1'b0, '0, k < nd - 1);
      end
    join
    check("tie_order_len", 128'(order_q.size()), 128'(exp_seq.size()));
    for (int k = 0; k < exp_seq.size() && k < order_q.size(); k++) begin
      check($sformatf("tie_grant_%0d", k), 128'(order_q[k]), 128'(exp_seq[k]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    i_last = '0; d_last = '0;

    // Reset state, and busywait follows the requests.
    #1;
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_mem_write", 128'(mem_write), 128'(0));
    check("rst_mem_address", 128'(mem_address), 128'(0));
    check("rst_mem_writedata", mem_writedata, 128'(0));
    check("rst_i_readdata", i_readdata, 128'(0));
    check("rst_d_readdata", d_readdata, 128'(0));
    check("rst_i_busywait_idle", 128'(i_busywait), 128'(0));
    i_read = 1'b1;
    #1;
    check("rst_i_busywait_req", 128'(i_busywait), 128'(1));
    check("rst_d_busywait_idle", 128'(d_busywait), 128'(0));
    d_write = 1'b1;
    #1;
    check("rst_d_busywait_req", 128'(d_busywait), 128'(1));
    i_read = 1'b0;
    d_write = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single i-cache read: 2 + memory busy cycles from the sampling edge to ACK.
    i_xact(AW'(28'h0000010), 1'b0);
    check("i_latency", 128'(i_ack_cyc - (i_raise_cyc + 1)), 128'(2 + MEM_BUSY));

    // d-cache write-back.
    d_xact(AW'(28'h0000020), 1'b1, {4{32'h11111111}}, 1'b0);
    check("d_wb_latency", 128'(d_ack_cyc - (d_raise_cyc + 1)), 128'(2 + MEM_BUSY));
    #1;
    check("d_busywait_after_ack", 128'(d_busywait), 128'(0));

    // Simultaneous requests, each dropped after its own ACK.
    do_reset();
    tie_test(1, 1);
    check("tie_i_after_d", 128'(i_ack_cyc - d_ack_cyc), 128'(2 + 2 + MEM_BUSY));

    // Both requests held back to back.
    do_reset();
    tie_test(2, 2);

    // i_read held across ACK re-issues the same read right after the IDLE cycle.
    i_xact(AW'(28'h0000010), 1'b1);
    c = i_ack_cyc;
    i_xact(AW'(28'h0000010), 1'b0);
    check("reissue_cycle", 128'(rise_cyc), 128'(c + 2));
    check("reissue_address", 128'(rise_addr), 128'(28'h0000010));
    check("reissue_is_read", 128'(rise_wr), 128'(0));

    // Randomized traffic from both caches.
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_xact(AW'($urandom_range(0, 31)), 1'b0);
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          d_xact(AW'(32 + $urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
      end
    join
    // Guarantee a non-zero d_readdata before the reset-in-flight case.
    d_xact(AW'(28'h0000021), 1'b0, '0, 1'b0);

    // Reset during WAIT: outputs clear at once, no ACK, held request restarts.
    @(posedge clk);
    #2;
    i_address = AW'(28'h0000010);
    i_read    = 1'b1;
    c         = i_acks;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_mem_busy", 128'(mem_busywait), 128'(1));
    #1;
    reset  = 1'b1;
    i_last = '0;
    d_last = '0;
    #1;
    check("rst_wait_mem_read", 128'(mem_read), 128'(0));
    check("rst_wait_mem_write", 128'(mem_write), 128'(0));
    check("rst_wait_mem_address", 128'(mem_address), 128'(0));
    check("rst_wait_mem_writedata", mem_writedata, 128'(0));
    check("rst_wait_i_readdata", i_readdata, 128'(0));
    check("rst_wait_d_readdata", d_readdata, 128'(0));
    check("rst_wait_i_busywait", 128'(i_busywait), 128'(1));
    @(posedge clk);
    #2;
    reset = 1'b0;
    check("rst_wait_no_ack", 128'(i_acks), 128'(c));
    i_q.delete();
    i_xact(AW'(28'h0000010), 1'b0);

    repeat (4) @(posedge clk);
    check("i_q_drained", 128'(i_q.size()), 128'(0));
    check("d_q_drained", 128'(d_q.size()), 128'(0));
    check("wb_q_drained", 128'(w_exp.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
